// File: rtl/bcd_pkg.sv
// Shared BCD digit constants and the load-value clamp helper.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    // Non-decimal nibbles (A..F) are forced to 9 so no illegal digit is stored.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: clear/load/increment/decrement with ripple carry and borrow.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       inc,
    input  logic       dec,
    input  logic       cin,
    input  logic       bin,
    input  logic       clr,
    input  logic       ld,
    input  logic [3:0] ld_val,
    output logic [3:0] digit,
    output logic       cout,
    output logic       bout
);

    logic [3:0] r_digit;

    // Carry/borrow ripple out only when this digit is at its limit and the
    // lower digits are also rolling over.
    assign cout  = cin & (r_digit == BCD_MAX);
    assign bout  = bin & (r_digit == BCD_ZERO);
    assign digit = r_digit;

    // Digit register; clear beats load beats count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_digit <= BCD_ZERO;
        end else if (clr) begin
            r_digit <= BCD_ZERO;
        end else if (ld) begin
            r_digit <= bcd_clamp(ld_val);
        end else if (inc && cin) begin
            r_digit <= (r_digit == BCD_MAX) ? BCD_ZERO : r_digit + 4'd1;
        end else if (dec && bin) begin
            r_digit <= (r_digit == BCD_ZERO) ? BCD_MAX : r_digit - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with load, wrap/saturate, limit pulses and
// leading-zero blank mask for the 7-segment display path.
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  en,
    input  logic                  up,
    input  logic                  down,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  ovf,
    output logic                  unf,
    output logic                  is_zero,
    output logic [DIGITS-1:0]     blank
);

    localparam logic SAT_EN   = (SATURATE != 0);
    localparam logic BLANK_EN = (BLANK_LZ != 0);

    logic [DIGITS:0] w_carry;
    logic [DIGITS:0] w_borrow;
    logic            w_clr;
    logic            w_ld;
    logic            w_inc_req;
    logic            w_dec_req;
    logic            w_inc;
    logic            w_dec;
    logic            w_hi_zero;
    logic            r_ovf;
    logic            r_unf;

    assign w_carry[0]  = 1'b1;
    assign w_borrow[0] = 1'b1;

    // Request priority: clear > load > (up & down cancel) > up > down.
    always_comb begin
        w_clr     = clear;
        w_ld      = load & ~clear;
        w_inc_req = en & up & ~down & ~clear & ~load;
        w_dec_req = en & down & ~up & ~clear & ~load;
    end

    // In saturate mode a top-level carry/borrow suppresses the whole update,
    // so the count holds at all-9s or zero instead of wrapping.
    assign w_inc = w_inc_req & ~(SAT_EN & w_carry[DIGITS]);
    assign w_dec = w_dec_req & ~(SAT_EN & w_borrow[DIGITS]);

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .CLK    (CLK),
            .RST    (RST),
            .inc    (w_inc),
            .dec    (w_dec),
            .cin    (w_carry[g]),
            .bin    (w_borrow[g]),
            .clr    (w_clr),
            .ld     (w_ld),
            .ld_val (load_value[4*g +: 4]),
            .digit  (count[4*g +: 4]),
            .cout   (w_carry[g+1]),
            .bout   (w_borrow[g+1])
        );
    end

    // Limit pulses: one cycle after an increment/decrement crosses a limit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_inc_req & w_carry[DIGITS];
            r_unf <= w_dec_req & w_borrow[DIGITS];
        end
    end

    assign ovf     = r_ovf;
    assign unf     = r_unf;
    assign is_zero = (count == '0);

    // Blank mask: scan from the top digit down while digits stay zero; units never blank.
    always_comb begin
        blank     = '0;
        w_hi_zero = 1'b1;
        for (int unsigned k = 0; k + 1 < DIGITS; k++) begin
            w_hi_zero             = w_hi_zero & (count[4*(DIGITS-1-k) +: 4] == BCD_ZERO);
            blank[DIGITS-1-k]     = w_hi_zero & BLANK_EN;
        end
    end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Scoreboard bench: wrap and saturate instances share stimulus; an integer
// reference model queues expected results, a monitor pops and compares.
module tb_bcd_counter_n;

    localparam int MAXV = 9999;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        en = 1'b0, up = 1'b0, down = 1'b0, clear = 1'b0, load = 1'b0;
    logic [15:0] load_value = '0;

    logic [15:0] count0, count1;
    logic        ovf0, unf0, z0, ovf1, unf1, z1;
    logic [3:0]  blank0, blank1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int v;
        bit o;
        bit u;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   mv[2];

    always #5 CLK = ~CLK;

    bcd_counter_n #(.DIGITS(4), .SATURATE(0), .BLANK_LZ(1)) dut_wrap (
        .CLK(CLK), .RST(RST), .en(en), .up(up), .down(down), .clear(clear),
        .load(load), .load_value(load_value), .count(count0), .ovf(ovf0),
        .unf(unf0), .is_zero(z0), .blank(blank0)
    );

    bcd_counter_n #(.DIGITS(4), .SATURATE(1), .BLANK_LZ(1)) dut_sat (
        .CLK(CLK), .RST(RST), .en(en), .up(up), .down(down), .clear(clear),
        .load(load), .load_value(load_value), .count(count1), .ovf(ovf1),
        .unf(unf1), .is_zero(z1), .blank(blank1)
    );

    function automatic logic [15:0] int_to_bcd(input int v);
        logic [15:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] blank_of(input int v);
        logic [3:0] b;
        int p;
        b = '0;
        p = 10;
        for (int i = 1; i < 4; i++) begin
            b[i] = (v < p);
            p = p * 10;
        end
        return b;
    endfunction

    function automatic int load_to_int(input logic [15:0] lv);
        int v, p, d;
        v = 0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            v = v + d * p;
            p = p * 10;
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_inst(input string tag, input exp_t e, input logic [15:0] c,
                              input logic o, input logic u, input logic z, input logic [3:0] b);
        check({tag, "count"},   32'(c), 32'(int_to_bcd(e.v)));
        check({tag, "ovf"},     32'(o), 32'(e.o));
        check({tag, "unf"},     32'(u), 32'(e.u));
        check({tag, "is_zero"}, 32'(z), 32'(e.v == 0));
        check({tag, "blank"},   32'(b), 32'(blank_of(e.v)));
    endtask

    // Reference model: instance 0 wraps, instance 1 saturates.
    task automatic model_edge(input logic c, input logic l, input logic e, input logic u,
                              input logic d, input logic [15:0] lv);
        for (int k = 0; k < 2; k++) begin
            exp_t x;
            x.o = 1'b0;
            x.u = 1'b0;
            if (c) begin
                mv[k] = 0;
            end else if (l) begin
                mv[k] = load_to_int(lv);
            end else if (e && u && d) begin
                mv[k] = mv[k];
            end else if (e && u) begin
                if (mv[k] == MAXV) begin
                    x.o = 1'b1;
                    mv[k] = (k == 1) ? MAXV : 0;
                end else begin
                    mv[k] = mv[k] + 1;
                end
            end else if (e && d) begin
                if (mv[k] == 0) begin
                    x.u = 1'b1;
                    mv[k] = (k == 1) ? 0 : MAXV;
                end else begin
                    mv[k] = mv[k] - 1;
                end
            end
            x.v = mv[k];
            if (k == 0) q0.push_back(x);
            else        q1.push_back(x);
        end
    endtask

    task automatic cyc(input logic c, input logic l, input logic e, input logic u,
                       input logic d, input logic [15:0] lv);
        clear = c; load = l; en = e; up = u; down = d; load_value = lv;
        model_edge(c, l, e, u, d, lv);
        @(negedge CLK);
    endtask

    // Monitor: the counter presents a result every edge; compare away from the edge.
    always @(posedge CLK) begin
        exp_t e;
        #2;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check_inst("wrap_", e, count0, ovf0, unf0, z0, blank0);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check_inst("sat_", e, count1, ovf1, unf1, z1, blank1);
        end
    end

    initial begin
        exp_t e0;
        logic c, l, e, u, d;
        logic [15:0] lv;

        RST = 1'b1;
        #12;
        e0.v = 0; e0.o = 1'b0; e0.u = 1'b0;
        check_inst("rst_wrap_", e0, count0, ovf0, unf0, z0, blank0);
        check_inst("rst_sat_",  e0, count1, ovf1, unf1, z1, blank1);
        @(negedge CLK);
        RST = 1'b0;
        mv[0] = 0;
        mv[1] = 0;

        for (int i = 0; i < 10000; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);

        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h9998);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);

        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);

        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h3F2A);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h1234);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0042);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);

        for (int i = 0; i < 3000; i++) begin
            c = ($urandom_range(0, 49) == 0);
            l = ($urandom_range(0, 19) == 0);
            e = ($urandom_range(0, 3) != 0);
            u = 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 2))
                0:       lv = 16'($urandom);
                1:       lv = 16'h9997;
                default: lv = 16'h0002;
            endcase
            cyc(c, l, e, u, d, lv);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Overflow pulse, then async reset while the pulse is still high.
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h9999);
        clear = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1; down = 1'b0; load_value = '0;
        model_edge(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        check("arst_wrap_ovf",   32'(ovf0),   32'd0);
        check("arst_wrap_count", 32'(count0), 32'd0);
        check("arst_sat_ovf",    32'(ovf1),   32'd0);
        check("arst_sat_count",  32'(count1), 32'd0);
        check("arst_wrap_zero",  32'(z0),     32'd1);
        check("arst_sat_zero",   32'(z1),     32'd1);
        @(negedge CLK);
        RST = 1'b0;
        up = 1'b0;
        en = 1'b0;
        mv[0] = 0;
        mv[1] = 0;
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

        @(posedge CLK);
        #4;
        check("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_counter_n.md
Name: bcd_counter_n

Overview:
- Parametrised N-digit BCD up/down counter; successor to the fixed 4-digit up/clear counter that feeds the 7-segment displays.
- Adds down-counting, parallel load, wrap or saturate mode, and overflow/underflow pulses.
- Adds a leading-zero blanking mask for display_7_seg consumers.
- Sits between the debouncers (single-cycle up/down/clear pulses) and the display multiplexers.

Parameters:
- DIGITS, 4, number of BCD digits (1..8); count range 0 .. 10^DIGITS-1.
- SATURATE, 0, 0 = wrap at limits; 1 = hold at limits.
- BLANK_LZ, 1, 1 = drive the blank mask; 0 = blank tied to all-zero.

Ports:
- CLK  in  1  system clock, all state on posedge.
- RST  in  1  asynchronous, active-high reset.
- en  in  1  count enable; gates up/down only, not clear/load.
- up  in  1  single-cycle increment request.
- down  in  1  single-cycle decrement request.
- clear  in  1  synchronous clear to zero.
- load  in  1  synchronous parallel load.
- load_value  in  4*DIGITS  packed BCD load data; digit 0 in [3:0].
- count  out  4*DIGITS  packed BCD count; digit 0 (units) in [3:0].
- ovf  out  1  one-cycle pulse: increment past the maximum (wrapped or saturated).
- unf  out  1  one-cycle pulse: decrement below zero (wrapped or saturated).
- is_zero  out  1  high when count == 0.
- blank  out  DIGITS  bit i high when digit i and all higher digits are zero; bit 0 always 0.

Behaviour:
- RST high (async): count = 0, ovf = 0, unf = 0. is_zero = 1 and blank = {DIGITS-1 ones, 0} follow combinationally.
- Latency: a request sampled at edge k is visible on count after edge k. ovf/unf are registered and high for exactly the cycle after the causing edge.
- Priority per edge: clear > load > (en & up & down: no change, no pulse) > en & up > en & down > hold.
- Increment:
  - Ripple BCD carry, digit by digit: a digit at 9 goes to 0 and carries; otherwise it adds 1 and carry stops.
  - Carry out of the top digit: SATURATE=0 gives count = 0 with ovf = 1; SATURATE=1 holds all-9s with ovf = 1.
- Decrement:
  - Ripple borrow: a digit at 0 goes to 9 and borrows; otherwise it subtracts 1.
  - Borrow out of the top digit: SATURATE=0 gives all-9s with unf = 1; SATURATE=1 holds 0 with unf = 1.
- Load:
  - Each nibble of load_value greater than 9 is clamped to 9; no pulses are generated.
  - Clear wins over a simultaneous load.
- Clear and load ignore en. up/down with en low are dropped, not queued.
- Multi-cycle up stays high: counts once per cycle. Debouncing and edge detection are the caller's job.
- Digits always hold a value in 0..9; no illegal BCD state is reachable.
- RST asserted mid-operation (e.g. the same cycle as ovf) clears ovf/unf immediately.
- is_zero and blank are combinational from the count register, with no extra latency.

Decomposition:
- Package bcd_pkg: BCD_MAX = 4'd9, BCD_ZERO = 4'd0, function bcd_clamp(nibble).
- Sub-module bcd_digit, instantiated DIGITS times in a generate loop:
  - Inputs: inc, dec, cin/bin, clr, ld, ld_val.
  - Outputs: digit[3:0], cout, bout.
- Top level handles priority, the saturate/wrap decision at the top carry, the pulse registers and the blank mask.

Test Plan:
- Reset, then 10000 up pulses (en=1, DIGITS=4, SATURATE=0) -> count 0009 after 9 pulses; rolls 0009->0010, 0099->0100 and 9999->0000 at the final pulse, ovf high for exactly one cycle.
- SATURATE=1, load 9998, then 3 up pulses -> 9999, 9999, 9999; ovf pulses on the 2nd and 3rd. Clear -> 0000; down pulse -> 0000 with unf = 1.
- SATURATE=0, count 0100, down pulse -> 0099 with blank = 1100 and is_zero = 0. Load 0000, down -> 9999 with unf = 1.
- Load 0x3F2A -> count 3929 (clamped). Load and clear in the same cycle -> 0000. up and down in the same cycle from 0042 -> stays 0042, no pulses.
- en = 0 with up pulses -> count unchanged. RST asserted asynchronously mid-cycle while ovf is high -> count 0000 and ovf 0 before the next CLK edge.
